// File: rtl/block_fetch_memory_if.sv
// Cache-to-memory bus for block_fetch_memory: miss request, block return, fetch stats and the
// preload write port used by the loader.
interface block_fetch_memory_if #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned WORD_COUNT = 4
);
    logic                            memRead;
    logic [ADDR_WIDTH-1:0]           address;
    logic                            wrEn;
    logic [ADDR_WIDTH-1:0]           wrAddr;
    logic [WORD_SIZE-1:0]            wrData;
    logic [WORD_SIZE*WORD_COUNT-1:0] dataOut;
    logic                            dataValid;
    logic                            busy;
    logic [13:0]                     fetchCount;

    modport master (
        output memRead, address, wrEn, wrAddr, wrData,
        input  dataOut, dataValid, busy, fetchCount
    );

    modport slave (
        input  memRead, address, wrEn, wrAddr, wrData,
        output dataOut, dataValid, busy, fetchCount
    );
endinterface

// File: rtl/block_fetch_memory.sv
// Main memory behind the direct-mapped cache: fetches an aligned block after a fixed latency,
// suppresses refetch of the block it last served, and counts completed fetches.
module block_fetch_memory #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned WORD_COUNT = 4,
    parameter int unsigned LATENCY    = 3
) (
    input  logic                clk,
    input  logic                rst,
    block_fetch_memory_if.slave bus
);
    localparam int unsigned OffW     = $clog2(WORD_COUNT);
    localparam int unsigned BlkW     = ADDR_WIDTH - OffW;
    localparam int unsigned LineW    = WORD_SIZE * WORD_COUNT;
    localparam logic [3:0]  CntInit  = 4'(LATENCY - 1);
    localparam logic [13:0] CountMax = '1;

    typedef enum logic {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [3:0]        counter_q, counter_d;
    logic [BlkW-1:0]   blk_addr_q, blk_addr_d;
    logic [BlkW-1:0]   last_block_q, last_block_d;
    logic              last_valid_q, last_valid_d;
    logic [LineW-1:0]  data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              busy_q, busy_d;
    logic [13:0]       fetch_count_q, fetch_count_d;

    logic [WORD_SIZE-1:0] mem [2**ADDR_WIDTH];
    logic [LineW-1:0]     block_rd;
    logic [BlkW-1:0]      req_block;
    logic [BlkW-1:0]      wr_block;
    logic                 unused_addr_offset;

    assign req_block          = bus.address[ADDR_WIDTH-1:OffW];
    assign wr_block           = bus.wrAddr[ADDR_WIDTH-1:OffW];
    assign unused_addr_offset = ^bus.address[OffW-1:0];

    // Not reset: contents survive rst so preloaded data stays usable.
    always_ff @(posedge clk) begin
        if (bus.wrEn) begin
            mem[bus.wrAddr] <= bus.wrData;
        end
    end

    always_comb begin
        block_rd = '0;
        for (int i = 0; i < int'(WORD_COUNT); i++) begin
            block_rd[i*WORD_SIZE +: WORD_SIZE] = mem[{blk_addr_q, OffW'(i)}];
        end
    end

    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        blk_addr_d    = blk_addr_q;
        last_block_d  = last_block_q;
        last_valid_d  = last_valid_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        busy_d        = busy_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            StIdle: begin
                if (bus.memRead && (!last_valid_q || (req_block != last_block_q))) begin
                    blk_addr_d = req_block;
                    counter_d  = CntInit;
                    busy_d     = 1'b1;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (counter_q == 4'd0) begin
                    data_out_d   = block_rd;
                    data_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    last_block_d = blk_addr_q;
                    last_valid_d = 1'b1;
                    if (fetch_count_q != CountMax) begin
                        fetch_count_d = fetch_count_q + 14'd1;
                    end
                    state_d = StIdle;
                end else begin
                    counter_d = counter_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Compare against the post-completion block so a same-edge write still invalidates it.
        if (bus.wrEn && (wr_block == last_block_d)) begin
            last_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            counter_q     <= '0;
            blk_addr_q    <= '0;
            last_block_q  <= '0;
            last_valid_q  <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            blk_addr_q    <= blk_addr_d;
            last_block_q  <= last_block_d;
            last_valid_q  <= last_valid_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            busy_q        <= busy_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.dataOut    = data_out_q;
    assign bus.dataValid  = data_valid_q;
    assign bus.busy       = busy_q;
    assign bus.fetchCount = fetch_count_q;
endmodule

// File: tb/tb_block_fetch_memory.sv
// Directed bench for block_fetch_memory: cycle table on a LATENCY=3 instance plus hand sequences
// for hold suppression, mid-fetch reset and counter saturation on a LATENCY=1 instance.
module tb_block_fetch_memory;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    block_fetch_memory_if #(.ADDR_WIDTH(15), .WORD_SIZE(32), .WORD_COUNT(4)) bus0 ();
    block_fetch_memory_if #(.ADDR_WIDTH(15), .WORD_SIZE(32), .WORD_COUNT(4)) bus1 ();

    block_fetch_memory #(.ADDR_WIDTH(15), .WORD_SIZE(32), .WORD_COUNT(4), .LATENCY(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    block_fetch_memory #(.ADDR_WIDTH(15), .WORD_SIZE(32), .WORD_COUNT(4), .LATENCY(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mem_read;
        logic [14:0] addr;
        logic        wr_en;
        logic [14:0] wr_addr;
        logic [31:0] wr_data;
        logic        exp_busy;
        logic        exp_valid;
        logic [13:0] exp_count;
        logic [127:0] exp_data;
    } vec_t;

    localparam int NumVecs = 27;
    vec_t vecs [NumVecs];

    localparam logic [127:0] DA  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] DA5 = {32'hA3, 32'hA2, 32'h55, 32'hA0};
    localparam logic [127:0] DB  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    localparam logic [127:0] DC1 = {32'hC3, 32'hB2, 32'hB1, 32'hB0};
    localparam logic [127:0] DC2 = {32'hC3, 32'hB2, 32'hB1, 32'hC0};

    function automatic vec_t mk(input logic mr, input logic [14:0] a, input logic we,
                                input logic [14:0] wa, input logic [31:0] wd, input logic b,
                                input logic v, input logic [13:0] c, input logic [127:0] d);
        vec_t r;
        r.mem_read = mr; r.addr = a; r.wr_en = we; r.wr_addr = wa; r.wr_data = wd;
        r.exp_busy = b; r.exp_valid = v; r.exp_count = c; r.exp_data = d;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dut0(input string tag, input logic b, input logic v,
                              input logic [13:0] c, input logic [127:0] d);
        check({tag, " busy"}, 128'(bus0.busy), 128'(b));
        check({tag, " dataValid"}, 128'(bus0.dataValid), 128'(v));
        check({tag, " fetchCount"}, 128'(bus0.fetchCount), 128'(c));
        check({tag, " dataOut"}, bus0.dataOut, d);
    endtask

    task automatic apply_vec(input int i);
        bus0.memRead = vecs[i].mem_read;
        bus0.address = vecs[i].addr;
        bus0.wrEn    = vecs[i].wr_en;
        bus0.wrAddr  = vecs[i].wr_addr;
        bus0.wrData  = vecs[i].wr_data;
        step();
        check_dut0($sformatf("vec%0d", i), vecs[i].exp_busy, vecs[i].exp_valid,
                   vecs[i].exp_count, vecs[i].exp_data);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus0.memRead = 1'b0; bus0.address = '0; bus0.wrEn = 1'b0; bus0.wrAddr = '0;
        bus0.wrData  = '0;
        bus1.memRead = 1'b0; bus1.address = '0; bus1.wrEn = 1'b0; bus1.wrAddr = '0;
        bus1.wrData  = '0;

        //            mr  addr      we  waddr     wdata   busy valid cnt data
        vecs[0]  = mk(1, 15'h1232, 0, 15'h0,    32'h0,  1, 0, 0, '0);
        vecs[1]  = mk(1, 15'h1232, 0, 15'h0,    32'h0,  1, 0, 0, '0);
        vecs[2]  = mk(1, 15'h1232, 0, 15'h0,    32'h0,  1, 0, 0, '0);
        vecs[3]  = mk(1, 15'h1232, 0, 15'h0,    32'h0,  0, 1, 1, DA);
        vecs[4]  = mk(1, 15'h1231, 1, 15'h1231, 32'h55, 0, 0, 1, DA);
        vecs[5]  = mk(1, 15'h1231, 0, 15'h0,    32'h0,  1, 0, 1, DA);
        vecs[6]  = mk(1, 15'h1231, 0, 15'h0,    32'h0,  1, 0, 1, DA);
        vecs[7]  = mk(1, 15'h1231, 0, 15'h0,    32'h0,  1, 0, 1, DA);
        vecs[8]  = mk(1, 15'h1231, 0, 15'h0,    32'h0,  0, 1, 2, DA5);
        vecs[9]  = mk(1, 15'h4000, 0, 15'h0,    32'h0,  1, 0, 2, DA5);
        vecs[10] = mk(1, 15'h1230, 0, 15'h0,    32'h0,  1, 0, 2, DA5);
        vecs[11] = mk(1, 15'h1230, 0, 15'h0,    32'h0,  1, 0, 2, DA5);
        vecs[12] = mk(1, 15'h1230, 0, 15'h0,    32'h0,  0, 1, 3, DB);
        vecs[13] = mk(1, 15'h1230, 0, 15'h0,    32'h0,  1, 0, 3, DB);
        vecs[14] = mk(1, 15'h1230, 0, 15'h0,    32'h0,  1, 0, 3, DB);
        vecs[15] = mk(1, 15'h1230, 0, 15'h0,    32'h0,  1, 0, 3, DB);
        vecs[16] = mk(1, 15'h1230, 0, 15'h0,    32'h0,  0, 1, 4, DA5);
        vecs[17] = mk(1, 15'h1230, 0, 15'h0,    32'h0,  0, 0, 4, DA5);
        vecs[18] = mk(1, 15'h4002, 0, 15'h0,    32'h0,  1, 0, 4, DA5);
        vecs[19] = mk(1, 15'h4002, 0, 15'h0,    32'h0,  1, 0, 4, DA5);
        vecs[20] = mk(1, 15'h4002, 1, 15'h4003, 32'hC3, 1, 0, 4, DA5);
        vecs[21] = mk(1, 15'h4002, 1, 15'h4000, 32'hC0, 0, 1, 5, DC1);
        vecs[22] = mk(1, 15'h4002, 0, 15'h0,    32'h0,  1, 0, 5, DC1);
        vecs[23] = mk(1, 15'h4002, 0, 15'h0,    32'h0,  1, 0, 5, DC1);
        vecs[24] = mk(1, 15'h4002, 0, 15'h0,    32'h0,  1, 0, 5, DC1);
        vecs[25] = mk(1, 15'h4002, 0, 15'h0,    32'h0,  0, 1, 6, DC2);
        vecs[26] = mk(1, 15'h4002, 0, 15'h0,    32'h0,  0, 0, 6, DC2);

        // Preload while reset is held; the array is not reset.
        step();
        for (int i = 0; i < 8; i++) begin
            bus0.wrEn   = 1'b1;
            bus0.wrAddr = (i < 4) ? 15'(15'h1230 + i) : 15'(15'h4000 + i - 4);
            bus0.wrData = (i < 4) ? 32'(32'hA0 + i) : 32'(32'hB0 + i - 4);
            bus1.wrEn   = 1'b1;
            bus1.wrAddr = 15'(i);
            bus1.wrData = 32'(i + 1);
            step();
        end
        bus0.wrEn = 1'b0;
        bus1.wrEn = 1'b0;

        check_dut0("reset", 1'b0, 1'b0, 14'd0, '0);
        check("reset dut1 fetchCount", 128'(bus1.fetchCount), 128'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) apply_vec(i);

        // Held request inside the served block must not refetch.
        bus0.address = 15'h1231;
        for (int i = 0; i < 20; i++) begin
            step();
            check_dut0($sformatf("hold%0d", i), 1'b0, 1'b0, 14'd1, DA);
        end

        for (int i = 4; i < NumVecs; i++) apply_vec(i);

        // Reset one edge into a fetch, then re-accept after release.
        bus0.address = 15'h1232;
        step();
        check_dut0("rst pre", 1'b1, 1'b0, 14'd6, DC2);
        #2 rst = 1'b1;
        #1;
        check_dut0("rst async", 1'b0, 1'b0, 14'd0, '0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_dut0($sformatf("rst held%0d", i), 1'b0, 1'b0, 14'd0, '0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_dut0($sformatf("rst refetch%0d", i), 1'b1, 1'b0, 14'd0, '0);
        end
        step();
        check_dut0("rst refetch done", 1'b0, 1'b1, 14'd1, DA5);

        // LATENCY=1 instance: alternate blocks to drive the counter to saturation.
        bus1.memRead = 1'b1;
        for (int k = 0; k < 16383; k++) begin
            bus1.address = k[0] ? 15'h4 : 15'h0;
            step();
            if (k == 0) begin
                check("lat1 accept busy", 128'(bus1.busy), 128'd1);
                check("lat1 accept dataValid", 128'(bus1.dataValid), 128'd0);
            end
            step();
            if (k == 0) begin
                check("lat1 done dataValid", 128'(bus1.dataValid), 128'd1);
                check("lat1 done busy", 128'(bus1.busy), 128'd0);
                check("lat1 done dataOut", bus1.dataOut, {32'd4, 32'd3, 32'd2, 32'd1});
            end
        end
        check("sat reach fetchCount", 128'(bus1.fetchCount), 128'd16383);
        bus1.address = 15'h4;
        step();
        check("sat extra busy", 128'(bus1.busy), 128'd1);
        step();
        check("sat extra dataValid", 128'(bus1.dataValid), 128'd1);
        check("sat hold fetchCount", 128'(bus1.fetchCount), 128'd16383);
        check("sat extra dataOut", bus1.dataOut, {32'd8, 32'd7, 32'd6, 32'd5});
        step();
        check("sat pulse end", 128'(bus1.dataValid), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/block_fetch_memory.md
Name: block_fetch_memory

Overview:
- Main-memory stage that sits directly upstream of the direct-mapped cache.
- On a miss, the cache raises memRead with a 15-bit word address. This block fetches the aligned 4-word block after a fixed latency and returns it on a 128-bit bus in the packing the cache writes into its line.
- It also provides a preload write port for the bench/loader and a fetch counter for miss-rate statistics.

Parameters:
ADDR_WIDTH, 15, word address width; memory depth = 2^ADDR_WIDTH 32-bit words
WORD_SIZE, 32, bits per word
WORD_COUNT, 4, words per block; block offset = low 2 address bits
LATENCY, 3, cycles from request acceptance to dataValid; legal range 1..15

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset; asynchronous, active-high
memRead  in  1  fetch request from cache (level; may be held high)
address  in  15  word address; block base = address[14:2]
wrEn  in  1  preload write enable
wrAddr  in  15  preload word address
wrData  in  32  preload word
dataOut  out  128  fetched block; [31:0]=offset 0, [63:32]=offset 1, [95:64]=offset 2, [127:96]=offset 3
dataValid  out  1  one-cycle pulse, dataOut updated this cycle
busy  out  1  fetch in progress
fetchCount  out  14  completed fetches, saturating

Behaviour:
- Reset (async, any state): state=IDLE; dataOut=0; dataValid=0; busy=0; fetchCount=0; lastValid=0; counter=0.
  - Memory array contents are not reset.
  - A fetch in flight is aborted and produces no dataValid.
- States: IDLE, WAIT.
- IDLE: a request is accepted at edge T when memRead=1 AND (lastValid=0 OR address[14:2]!=lastBlock).
  - On acceptance: latch blkAddr=address[14:2]; counter=LATENCY-1; busy=1 from T; go WAIT.
  - A held memRead for the same, already-served block is not re-fetched.
- WAIT: counter decrements each edge; address and memRead are ignored.
- Completion: at the edge where counter==0 in WAIT (edge T+LATENCY):
  - dataOut <= mem[{blkAddr,2'd0..3}].
  - dataValid=1 for exactly one cycle; busy=0.
  - lastBlock=blkAddr; lastValid=1; fetchCount+1 (holds at 16383).
  - Return to IDLE.
- LATENCY=1: accept at T, complete at T+1.
- dataOut holds its value until the next completion. dataValid=0 in all other cycles.
- Earliest re-accept is the edge after completion (T+LATENCY+1), and only if the block differs or lastValid was cleared.
- Writes: when wrEn=1, mem[wrAddr]<=wrData at the edge, in any state.
  - A write whose wrAddr[14:2]==lastBlock clears lastValid, so a held request refetches fresh data.
  - A write at an edge before completion is visible in the fetched block. A write at the completion edge itself is not; the old word is returned.
  - A write and a completion of the same block at the same edge: completion sets lastValid=1 and the write clears it; clear wins.
- Simultaneous memRead and wrEn in IDLE: both take effect; the fetch sees the write only if it lands before the completion edge.

Test Plan:
- Preload mem[0x1230..0x1233]=0xA0,0xA1,0xA2,0xA3. Assert memRead with address=0x1232 at edge 0 -> busy=1 at edges 0-2; dataValid pulse at edge 3; dataOut=0x000000A3_000000A2_000000A1_000000A0; fetchCount=1.
- Hold memRead=1, address=0x1231 for 20 cycles after the first fetch -> no further busy/dataValid; fetchCount stays 1.
- Change address to 0x4000 while busy -> ignored until completion. Then a new fetch starts at the edge after completion, dataValid 3 cycles later, fetchCount=2.
- Write mem[0x1231]=0x55 while holding memRead on block 0x48C -> refetch; returned word 1 = 0x55.
- Assert rst at edge 1 of a fetch -> outputs 0 immediately, no dataValid. After release, the same request is re-accepted and completes LATENCY cycles later.
- Force fetchCount to 16383 via repeated distinct-block fetches (or LATENCY=1 sweep) -> the next completion keeps 16383.
